imem_sync: RTL and testbench

//  Parametrised, synchronous-read instruction memory for the ARM core fetch stage.
//  - Fetch channel: valid/ready request, 1-cycle latency, one response per request.
//  - Load channel: writes program images at run time; fetch is stalled while loading.
//  - Flags misaligned, out-of-range and (optionally) parity-corrupt fetches.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_if.sv | 34 +++
 rtl/imem_sp_ram.sv | 29 ++
 rtl/imem_sync.sv | 174 +++++++++++++++++
 tb/tb_imem_sync.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types for the synchronous instruction memory: response fault codes
// and the fetch/load controller states.
package imem_pkg;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_RANGE    = 2'd2,
        FLT_PARITY   = 2'd3
    } fault_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_if.sv
// Fetch, response and program-load signals of imem_sync.
// The core/loader side uses the master modport, the memory uses slave.
interface imem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import imem_pkg::*;

    logic              fetch_valid;
    logic              fetch_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    fault_e            rsp_fault;
    logic              load_en;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_wdata;
    logic              busy;

    modport master (
        output fetch_valid, fetch_addr, rsp_ready,
        output load_en, load_we, load_addr, load_wdata,
        input  fetch_ready, rsp_valid, rsp_data, rsp_fault, busy
    );

    modport slave (
        input  fetch_valid, fetch_addr, rsp_ready,
        input  load_en, load_we, load_addr, load_wdata,
        output fetch_ready, rsp_valid, rsp_data, rsp_fault, busy
    );

endinterface

// File: rtl/imem_sp_ram.sv
// Single-port synchronous RAM. The read register only updates on a read
// strobe, so it holds a stalled response across load cycles.
module imem_sp_ram #(
    parameter int MEM_W     = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 512,
    parameter int IDX_W     = 9,
    parameter     INIT_FILE = ""
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [MEM_W-1:0] wdata_i,
    output logic [MEM_W-1:0] rdata_o
);

    logic [MEM_W-1:0] mem [DEPTH];

    // Write has priority; reads happen only for accepted fetches.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end else if (re_i) begin
            rdata_o <= mem[idx_i];
        end
    end

endmodule

// File: rtl/imem_sync.sv
// Synchronous-read instruction memory with run-time program loading.
// Define IMEM_PARITY_EN to store an even-parity bit per word and flag FLT_PARITY.
module imem_sync
    import imem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 512,
    parameter     INIT_FILE = ""
) (
    input  logic   clk,
    input  logic   reset_n,
    imem_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = DATA_W + PAR_W;

    imem_state_e       state_q, state_d;
    logic              rsp_valid_q, rsp_valid_d;
    fault_e            fault_q, fault_d;
    logic              live_q, live_d;
    logic              fetch_ready_s;
    logic              accept_s;
    logic              ram_we_s;
    logic              ram_re_s;
    logic [IDX_W-1:0]  ram_idx_s;
    logic [MEM_W-1:0]  ram_wdata_s;
    logic [MEM_W-1:0]  ram_rdata_s;
    logic              par_err_s;
    fault_e            rsp_fault_s;
    logic [DATA_W-1:0] rsp_data_s;

    // Misalignment outranks range; no wrap-around above DEPTH words.
    function automatic fault_e addr_check(input logic [ADDR_W-1:0] a);
        fault_e f;
        if (a[1:0] != 2'b00) begin
            f = FLT_MISALIGN;
        end else if (a[ADDR_W-1:IDX_W+2] != '0) begin
            f = FLT_RANGE;
        end else begin
            f = FLT_NONE;
        end
        return f;
    endfunction

`ifdef IMEM_PARITY_EN
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    assign ram_wdata_s = {even_parity(bus.load_wdata), bus.load_wdata};
    assign par_err_s   = ^ram_rdata_s;
`else
    assign ram_wdata_s = bus.load_wdata;
    assign par_err_s   = 1'b0;
`endif

    // Controller next state and response-register next state.
    always_comb begin
        state_d       = state_q;
        rsp_valid_d   = rsp_valid_q;
        fault_d       = fault_q;
        live_d        = live_q;
        fetch_ready_s = (state_q == RUN) && !bus.load_en &&
                        (!rsp_valid_q || bus.rsp_ready);
        accept_s      = fetch_ready_s && bus.fetch_valid;

        case (state_q)
            RUN: begin
                if (bus.load_en) begin
                    state_d = rsp_valid_q ? DRAIN : LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (!rsp_valid_q || bus.rsp_ready) begin
                    state_d = bus.load_en ? LOAD : RUN;
                end else begin
                    state_d = DRAIN;
                end
            end
            LOAD: begin
                if (!bus.load_en) begin
                    state_d = RUN;
                end else begin
                    state_d = LOAD;
                end
            end
            default: state_d = RUN;
        endcase

        if (accept_s) begin
            rsp_valid_d = 1'b1;
            fault_d     = addr_check(bus.fetch_addr);
            live_d      = 1'b1;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // The single RAM port belongs to the loader in LOAD and to fetch otherwise.
    always_comb begin
        ram_we_s  = 1'b0;
        ram_re_s  = 1'b0;
        ram_idx_s = bus.fetch_addr[IDX_W+1:2];
        if (state_q == LOAD) begin
            ram_idx_s = bus.load_addr[IDX_W+1:2];
            ram_we_s  = bus.load_we && (addr_check(bus.load_addr) == FLT_NONE);
        end else begin
            ram_re_s  = accept_s;
        end
    end

    // Response fault/data: parity is only meaningful for a clean address.
    always_comb begin
        rsp_fault_s = fault_q;
        if ((fault_q == FLT_NONE) && live_q && par_err_s) begin
            rsp_fault_s = FLT_PARITY;
        end else begin
            rsp_fault_s = fault_q;
        end
        if ((rsp_fault_s == FLT_NONE) && live_q) begin
            rsp_data_s = ram_rdata_s[DATA_W-1:0];
        end else begin
            rsp_data_s = '0;
        end
    end

    // State and response registers; live_q keeps rsp_data at 0 until the first read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            rsp_valid_q <= 1'b0;
            fault_q     <= FLT_NONE;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            fault_q     <= fault_d;
            live_q      <= live_d;
        end
    end

    imem_sp_ram #(
        .MEM_W     (MEM_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we_s),
        .re_i    (ram_re_s),
        .idx_i   (ram_idx_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    assign bus.fetch_ready = fetch_ready_s;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_s;
    assign bus.rsp_fault   = rsp_fault_s;
    assign bus.busy        = (state_q != RUN);

endmodule

// File: tb/tb_imem_sync.sv
// Bench for imem_sync: constant-table fetches, directed load/drain/reset
// sequences and random traffic against a queue-based reference model.
module tb_imem_sync;
    import imem_pkg::*;

    localparam int DEPTH = 512;
`ifdef IMEM_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_LOAD  = 2;

    logic clk;
    logic reset_n;

    imem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    imem_sync #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .INIT_FILE ("")
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        fault_e      fault;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        fault_e      fault;
    } vec_t;

    logic [31:0] m_mem [DEPTH];
    bit          m_bad [DEPTH];
    rsp_t        m_q [$];
    int          m_mode;
    int          n_vec;
    int          n_err;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic rsp_t expect_fetch(input logic [31:0] a);
        rsp_t r;
        r.data = 32'd0;
        if (a % 32'd4 != 32'd0) begin
            r.fault = FLT_MISALIGN;
        end else if (a / 32'd4 >= DEPTH) begin
            r.fault = FLT_RANGE;
        end else if (PAR_BUILD && m_bad[a / 32'd4]) begin
            r.fault = FLT_PARITY;
        end else begin
            r.fault = FLT_NONE;
            r.data  = m_mem[a / 32'd4];
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7) return {21'd0, 9'($urandom_range(0, DEPTH - 1)), 2'b00};
        else if (sel == 7) return ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        else if (sel == 8) return (32'(DEPTH) + 32'($urandom_range(0, 1000))) * 32'd4;
        else return $urandom;
    endfunction

    // One clock of stimulus; the model advances on the edge and checks follow.
    task automatic cycle(input bit fv, input logic [31:0] fa, input bit rr,
                         input bit le, input bit lw, input logic [31:0] la,
                         input logic [31:0] ld);
        bit   exp_rdy;
        bit   acc;
        bit   had_rsp;
        rsp_t front;
        bus.fetch_valid = fv;
        bus.fetch_addr  = fa;
        bus.rsp_ready   = rr;
        bus.load_en     = le;
        bus.load_we     = lw;
        bus.load_addr   = la;
        bus.load_wdata  = ld;
        #1;
        exp_rdy = (m_mode == M_RUN) && !le && (m_q.size() == 0 || rr);
        chk("fetch_ready", 64'(bus.fetch_ready), 64'(exp_rdy));
        acc = fv && exp_rdy;
        @(posedge clk);
        if (m_mode == M_LOAD && lw && (la % 32'd4 == 32'd0) && (la / 32'd4 < DEPTH)) begin
            m_mem[la / 32'd4] = ld;
            m_bad[la / 32'd4] = 1'b0;
        end
        had_rsp = (m_q.size() != 0);
        case (m_mode)
            M_RUN:   if (le) m_mode = had_rsp ? M_DRAIN : M_LOAD;
            M_DRAIN: if (!had_rsp || rr) m_mode = le ? M_LOAD : M_RUN;
            M_LOAD:  if (!le) m_mode = M_RUN;
            default: m_mode = M_RUN;
        endcase
        if (had_rsp && rr) void'(m_q.pop_front());
        if (acc) m_q.push_back(expect_fetch(fa));
        #1;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_q.size() != 0));
        chk("busy", 64'(bus.busy), 64'(m_mode != M_RUN));
        if (m_q.size() != 0) begin
            front = m_q[0];
            chk("rsp_data", 64'(bus.rsp_data), 64'(front.data));
            chk("rsp_fault", 64'(bus.rsp_fault), 64'(front.fault));
        end
    endtask

    vec_t        tbl [10];
    logic [31:0] held;
    int          burst;

    initial begin
        n_vec  = 0;
        n_err  = 0;
        m_mode = M_RUN;
        tbl[0] = '{32'h0000_0004, 32'hE3A0_0008, FLT_NONE};
        tbl[1] = '{32'h0000_0000, 32'h1357_9BDF, FLT_NONE};
        tbl[2] = '{32'h0000_0004, 32'hE3A0_0008, FLT_NONE};
        tbl[3] = '{32'h0000_0008, 32'h0246_8ACE, FLT_NONE};
        tbl[4] = '{32'h0000_0006, 32'h0000_0000, FLT_MISALIGN};
        tbl[5] = '{32'h0000_0800, 32'h0000_0000, FLT_RANGE};
        tbl[6] = '{32'h0000_07FC, 32'hCAFE_F00D, FLT_NONE};
        tbl[7] = '{32'hFFFF_FFFF, 32'h0000_0000, FLT_MISALIGN};
        tbl[8] = '{32'hFFFF_FFFC, 32'h0000_0000, FLT_RANGE};
        tbl[9] = '{32'h0000_0003, 32'h0000_0000, FLT_MISALIGN};

        reset_n         = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = 32'd0;
        bus.rsp_ready   = 1'b0;
        bus.load_en     = 1'b0;
        bus.load_we     = 1'b0;
        bus.load_addr   = 32'd0;
        bus.load_wdata  = 32'd0;
        #3;
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("reset_rsp_fault", 64'(bus.rsp_fault), 64'(FLT_NONE));
        chk("reset_busy", 64'(bus.busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Program the whole array through the load channel.
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] w;
            case (i)
                0:       w = 32'h1357_9BDF;
                1:       w = 32'hE3A0_0008;
                2:       w = 32'h0246_8ACE;
                DEPTH-1: w = 32'hCAFE_F00D;
                default: w = $urandom;
            endcase
            cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'(i * 4), w);
        end
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Back-to-back fetches from the constant table.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, tbl[i].addr, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            chk("tbl_valid", 64'(bus.rsp_valid), 64'd1);
            chk("tbl_data", 64'(bus.rsp_data), 64'(tbl[i].data));
            chk("tbl_fault", 64'(bus.rsp_fault), 64'(tbl[i].fault));
        end

        // Stalled consumer: nothing accepted and the response holds.
        held = bus.rsp_data;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            chk("hold_data", 64'(bus.rsp_data), 64'(held));
        end

        // Load request with a pending response drains first; DRAIN ignores writes.
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        chk("drain_busy", 64'(bus.busy), 64'd1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h5555_AAAA);
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0012, 32'h1234_5678);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0800, 32'hBAD0_BAD0);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("raw_data", 64'(bus.rsp_data), 64'h0000_0000_DEAD_BEEF);
        cycle(1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("no_wrap_write", 64'(bus.rsp_data), 64'h0000_0000_1357_9BDF);

        // load_en dropped while draining returns to RUN without loading.
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("drop_busy", 64'(bus.busy), 64'd1);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("drop_run", 64'(bus.busy), 64'd0);
        cycle(1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Asynchronous reset with a response outstanding.
        cycle(1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        bus.fetch_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("async_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("async_rsp_fault", 64'(bus.rsp_fault), 64'(FLT_NONE));
        m_q.delete();
        m_mode = M_RUN;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("post_reset_data", 64'(bus.rsp_data), 64'h0000_0000_E3A0_0008);

        // Random traffic with occasional load bursts.
        burst = 0;
        for (int i = 0; i < 800; i++) begin
            bit fv;
            bit rr;
            bit le;
            if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(2, 8);
            le = (burst > 0);
            if (burst > 0) burst--;
            fv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            cycle(fv, rand_addr(), rr, le, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end

        // Corrupt one stored bit of word 3 behind the controller's back.
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        dut.u_ram.mem[3][0] <= ~dut.u_ram.mem[3][0];
        m_mem[3] = m_mem[3] ^ 32'd1;
        m_bad[3] = 1'b1;
        #1;
        cycle(1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        if (PAR_BUILD) begin
            chk("parity_fault", 64'(bus.rsp_fault), 64'(FLT_PARITY));
            chk("parity_data", 64'(bus.rsp_data), 64'd0);
        end else begin
            chk("flip_fault", 64'(bus.rsp_fault), 64'(FLT_NONE));
            chk("flip_data", 64'(bus.rsp_data), 64'(m_mem[3]));
        end
        cycle(1'b1, 32'h0000_000E, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
